// File: rtl/ext_int_arb.sv
// ext_int_arb: external interrupt arbiter (PLIC-style) for a single core.
//
// Purpose:
//   Synchronises up to 15 raw interrupt lines and tracks pending, deferred
//   and in-service state for each one. Each source is edge- or
//   level-triggered. A registered arbiter picks the highest-priority
//   eligible source, with ties going to the lowest ID. exti is raised when
//   that source's priority is above THRESHOLD. Software takes the interrupt
//   with a claim (read address 20) and retires it with a complete (write
//   address 20).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   src        raw asynchronous requests, bit i is ID i+1
//   cfg_addr   register word index
//   cfg_wdata  write data
//   cfg_we     write strobe
//   cfg_re     read strobe
//   cfg_rdata  read data, valid the cycle after cfg_re
//   exti       registered request to the core's external-interrupt input
//
// Register map (word index):
//   0..SOURCES-1 PRIO[ID-1]  RW
//   16 PENDING RO, 17 ENABLE RW, 18 EDGE RW, 19 THRESHOLD RW,
//   20 CLAIM (read) / COMPLETE (write)

module ext_int_arb #(
  parameter int SOURCES = 8,
  parameter int PRIO_W  = 3,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SOURCES-1:0] src,
  input  logic [4:0]         cfg_addr,
  input  logic [XLEN-1:0]    cfg_wdata,
  input  logic               cfg_we,
  input  logic               cfg_re,
  output logic [XLEN-1:0]    cfg_rdata,
  output logic               exti
);

  localparam int ID_W = 4;

  localparam logic [4:0] ADDR_PENDING   = 5'd16;
  localparam logic [4:0] ADDR_ENABLE    = 5'd17;
  localparam logic [4:0] ADDR_EDGE      = 5'd18;
  localparam logic [4:0] ADDR_THRESHOLD = 5'd19;
  localparam logic [4:0] ADDR_CLAIM     = 5'd20;

  logic [SOURCES-1:0] src_meta;
  logic [SOURCES-1:0] srcs;
  logic [SOURCES-1:0] src_prev;
  logic [1:0]         sync_ok;
  logic [SOURCES-1:0] armed;

  logic [SOURCES-1:0] pending;
  logic [SOURCES-1:0] deferred;
  logic [SOURCES-1:0] in_service;

  logic [PRIO_W-1:0]  prio [SOURCES];
  logic [SOURCES-1:0] enable;
  logic [SOURCES-1:0] edge_en;
  logic [PRIO_W-1:0]  threshold;

  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;

  logic [ID_W-1:0]    arb_id;
  logic [PRIO_W-1:0]  arb_prio;
  logic [XLEN-1:0]    rd_val;
  logic [SOURCES-1:0] edge_det;
  logic [SOURCES-1:0] claim_hit;
  logic [SOURCES-1:0] complete_hit;
  logic [SOURCES-1:0] pending_n;
  logic [SOURCES-1:0] deferred_n;
  logic [SOURCES-1:0] in_service_n;
  logic               claim_go;

  // Only the low bits of the write data are architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  // A source may only produce an edge after it has been seen low with a
  // fully settled synchroniser. A line that is still high when reset is
  // released therefore does not count as a fresh edge.
  assign edge_det = srcs & ~src_prev & armed & edge_en;

  // Priority scan. The strict '>' keeps the lowest ID on a tie. A zero
  // priority never beats the initial zero, so it can never win.
  always_comb begin
    arb_id   = '0;
    arb_prio = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (pending[i] && enable[i] && (prio[i] != '0) && (prio[i] > arb_prio)) begin
        arb_prio = prio[i];
        arb_id   = ID_W'(i + 1);
      end
    end
  end

  // Read mux. It always sees the pre-write register values, so a read and
  // a write in the same cycle return the old contents.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (cfg_addr == 5'(i)) rd_val[PRIO_W-1:0] = prio[i];
    end
    case (cfg_addr)
      ADDR_PENDING:   rd_val[SOURCES-1:0] = pending;
      ADDR_ENABLE:    rd_val[SOURCES-1:0] = enable;
      ADDR_EDGE:      rd_val[SOURCES-1:0] = edge_en;
      ADDR_THRESHOLD: rd_val[PRIO_W-1:0]  = threshold;
      ADDR_CLAIM:     rd_val[ID_W-1:0]    = best_id;
      default:        ;
    endcase
  end

  // Claim and complete decode, followed by the per-source gateway.
  // In edge mode, an edge that arrives while the source is in service, or
  // in the same cycle as its claim, is parked in the one-deep deferred bit.
  // A complete releases that bit into pending. In level mode, pending
  // follows the synchronised line, masked while the source is in service.
  always_comb begin
    claim_go = cfg_re && (cfg_addr == ADDR_CLAIM) && (best_id != '0);
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < SOURCES; i++) begin
      claim_hit[i]    = claim_go && (best_id == ID_W'(i + 1));
      complete_hit[i] = cfg_we && (cfg_addr == ADDR_CLAIM) &&
                        (cfg_wdata[ID_W-1:0] == ID_W'(i + 1)) && in_service[i];
    end
    in_service_n = (in_service | claim_hit) & ~complete_hit;

    pending_n  = pending;
    deferred_n = deferred;
    for (int i = 0; i < SOURCES; i++) begin
      if (edge_en[i]) begin
        if (claim_hit[i]) pending_n[i] = 1'b0;
        if (edge_det[i]) begin
          if (in_service[i] || claim_hit[i]) deferred_n[i] = 1'b1;
          else                               pending_n[i]  = 1'b1;
        end
        if (complete_hit[i] && deferred_n[i]) begin
          pending_n[i]  = 1'b1;
          deferred_n[i] = 1'b0;
        end
      end else begin
        pending_n[i]  = srcs[i] & ~in_service_n[i];
        deferred_n[i] = 1'b0;
      end
    end
  end

  // All state, including the configuration registers. exti is computed
  // only from registered state, so there is no combinational path from
  // src or the config port to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_meta   <= '0;
      srcs       <= '0;
      src_prev   <= '0;
      sync_ok    <= '0;
      armed      <= '0;
      pending    <= '0;
      deferred   <= '0;
      in_service <= '0;
      for (int i = 0; i < SOURCES; i++) prio[i] <= '0;
      enable     <= '0;
      edge_en    <= '0;
      threshold  <= '0;
      best_id    <= '0;
      best_prio  <= '0;
      cfg_rdata  <= '0;
      exti       <= 1'b0;
    end else begin
      src_meta   <= src;
      srcs       <= src_meta;
      src_prev   <= srcs;
      sync_ok    <= {sync_ok[0], 1'b1};
      armed      <= armed | ({SOURCES{sync_ok[1]}} & ~srcs);

      pending    <= pending_n;
      deferred   <= deferred_n;
      in_service <= in_service_n;

      best_id    <= arb_id;
      best_prio  <= arb_prio;
      exti       <= (best_id != '0) && (best_prio > threshold);

      if (cfg_re) cfg_rdata <= rd_val;

      if (cfg_we) begin
        for (int i = 0; i < SOURCES; i++) begin
          if (cfg_addr == 5'(i)) prio[i] <= cfg_wdata[PRIO_W-1:0];
        end
        case (cfg_addr)
          ADDR_ENABLE:    enable    <= cfg_wdata[SOURCES-1:0];
          ADDR_EDGE:      edge_en   <= cfg_wdata[SOURCES-1:0];
          ADDR_THRESHOLD: threshold <= cfg_wdata[PRIO_W-1:0];
          default:        ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_int_arb.sv
// tb_ext_int_arb: self-checking bench for ext_int_arb.
// The first part is a table of register write/readback vectors. After that
// come hand-written multi-cycle sequences: edge latency, tie-break, the
// threshold, deferred edges, ignored completes, and reset.
// Read results go through a scoreboard queue.

module tb_ext_int_arb;

  localparam int SOURCES = 8;
  localparam int PRIO_W  = 3;
  localparam int XLEN    = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SOURCES-1:0] src = '0;
  logic [4:0]         cfg_addr = '0;
  logic [XLEN-1:0]    cfg_wdata = '0;
  logic               cfg_we = 1'b0;
  logic               cfg_re = 1'b0;
  logic [XLEN-1:0]    cfg_rdata;
  logic               exti;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string           name;
    logic [XLEN-1:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp;
    string           name;
  } vec_t;

  vec_t vecs[10];

  ext_int_arb #(.SOURCES(SOURCES), .PRIO_W(PRIO_W), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_rdata (cfg_rdata),
    .exti      (exti)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_output(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic reg_write(input logic [4:0] addr, input logic [XLEN-1:0] data);
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  // Push the expectation when the read is issued. Pop and compare it once
  // the registered read data is available.
  task automatic read_expect(input logic [4:0] addr, input logic [XLEN-1:0] exp,
                             input string name);
    sb_item_t item;
    cfg_addr = addr;
    cfg_re   = 1'b1;
    sb_q.push_back('{name, exp});
    step();
    cfg_re = 1'b0;
    if (sb_q.size() == 0) begin
      check_output({name, " scoreboard empty"}, 1, 0);
    end else begin
      item = sb_q.pop_front();
      check_output(item.name, cfg_rdata, item.exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reg_write(v.addr, v.wdata);
    read_expect(v.addr, v.exp, v.name);
  endtask

  task automatic do_reset();
    cfg_we = 1'b0;
    cfg_re = 1'b0;
    rst_n  = 1'b0;
    steps(2);
    rst_n  = 1'b1;
    steps(2);
  endtask

  initial begin
    vecs[0] = '{5'd0,  32'd5,     32'd5,    "prio id1"};
    vecs[1] = '{5'd1,  32'hFF,    32'd7,    "prio id2 mask"};
    vecs[2] = '{5'd7,  32'd6,     32'd6,    "prio id8"};
    vecs[3] = '{5'd8,  32'd3,     32'd0,    "unmapped 8"};
    vecs[4] = '{5'd17, 32'h1FF,   32'hFF,   "enable mask"};
    vecs[5] = '{5'd18, 32'hAA,    32'hAA,   "edge reg"};
    vecs[6] = '{5'd19, 32'hF,     32'd7,    "threshold mask"};
    vecs[7] = '{5'd16, 32'hFF,    32'd0,    "pending ro"};
    vecs[8] = '{5'd21, 32'd5,     32'd0,    "unmapped 21"};
    vecs[9] = '{5'd31, 32'd7,     32'd0,    "unmapped 31"};

    do_reset();
    read_expect(5'd17, 32'd0, "reset enable");
    check_output("reset exti", {31'd0, exti}, 32'd0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Write and read in the same cycle: the read returns the old value.
    cfg_addr = 5'd19; cfg_wdata = 32'd5; cfg_we = 1'b1; cfg_re = 1'b1;
    sb_q.push_back('{"rw same cycle", 32'd7});
    step();
    cfg_we = 1'b0; cfg_re = 1'b0;
    begin
      sb_item_t it;
      it = sb_q.pop_front();
      check_output(it.name, cfg_rdata, it.exp);
    end
    read_expect(5'd19, 32'd5, "threshold after rw");

    // Edge source ID3: exti rises 5 cycles after src, then claim.
    do_reset();
    reg_write(5'd2, 32'd2);
    reg_write(5'd17, 32'h04);
    reg_write(5'd18, 32'h04);
    reg_write(5'd19, 32'd0);
    steps(3);
    src[2] = 1'b1;
    steps(4);
    check_output("exti before latency", {31'd0, exti}, 32'd0);
    step();
    check_output("exti at latency 5", {31'd0, exti}, 32'd1);
    read_expect(5'd20, 32'd3, "claim id3");
    begin
      int k = 0;
      while (exti && k < 2) begin step(); k++; end
    end
    check_output("exti drop after claim", {31'd0, exti}, 32'd0);
    read_expect(5'd16, 32'd0, "pending after claim");
    reg_write(5'd20, 32'd3);
    src = '0;

    // Equal priorities on level sources: the lowest ID wins first.
    do_reset();
    reg_write(5'd1, 32'd5);
    reg_write(5'd4, 32'd5);
    reg_write(5'd17, 32'h12);
    src = 8'h12;
    steps(6);
    read_expect(5'd20, 32'd2, "tie claim id2");
    steps(2);
    read_expect(5'd20, 32'd5, "tie claim id5");
    steps(2);
    read_expect(5'd20, 32'd0, "tie claim none");
    steps(2);
    check_output("exti all in service", {31'd0, exti}, 32'd0);
    reg_write(5'd20, 32'd2);
    steps(2);
    read_expect(5'd20, 32'd2, "reclaim id2 nested");
    src = '0;

    // The threshold blocks an equal priority and passes a higher one.
    do_reset();
    reg_write(5'd19, 32'd4);
    reg_write(5'd0, 32'd4);
    reg_write(5'd17, 32'h01);
    src[0] = 1'b1;
    steps(8);
    check_output("exti blocked by threshold", {31'd0, exti}, 32'd0);
    reg_write(5'd19, 32'd3);
    check_output("exti one cycle after thr", {31'd0, exti}, 32'd0);
    step();
    check_output("exti two cycles after thr", {31'd0, exti}, 32'd1);
    src = '0;

    // Two edges while in service collapse into one deferred claim.
    do_reset();
    reg_write(5'd3, 32'd1);
    reg_write(5'd17, 32'h08);
    reg_write(5'd18, 32'h08);
    steps(3);
    src[3] = 1'b1;
    steps(6);
    read_expect(5'd20, 32'd4, "claim id4");
    for (int p = 0; p < 2; p++) begin
      src[3] = 1'b0; steps(3);
      src[3] = 1'b1; steps(3);
    end
    read_expect(5'd16, 32'd0, "pending while deferred");
    reg_write(5'd20, 32'd4);
    read_expect(5'd16, 32'h08, "pending after complete");
    steps(2);
    read_expect(5'd20, 32'd4, "deferred claim id4");
    steps(2);
    read_expect(5'd20, 32'd0, "no second deferred");
    src = '0;

    // Bogus completes are ignored. Reset in the middle of a sequence.
    do_reset();
    reg_write(5'd0, 32'd3);
    reg_write(5'd1, 32'd2);
    reg_write(5'd17, 32'h03);
    reg_write(5'd18, 32'h01);
    steps(3);
    src[0] = 1'b1;
    steps(6);
    read_expect(5'd20, 32'd1, "claim id1");
    reg_write(5'd20, 32'd0);
    reg_write(5'd20, 32'd9);
    reg_write(5'd20, 32'd2);
    step();
    src[0] = 1'b0; steps(3);
    src[0] = 1'b1; steps(3);
    read_expect(5'd16, 32'd0, "id1 still in service");
    read_expect(5'd0, 32'd3, "prio id1 unchanged");
    src[1] = 1'b1;
    steps(6);
    check_output("exti from id2", {31'd0, exti}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("async reset exti", {31'd0, exti}, 32'd0);
    check_output("async reset rdata", cfg_rdata, 32'd0);
    src = '0;
    step();
    rst_n = 1'b1;
    step();
    begin
      logic [4:0] regs [7];
      regs = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
      foreach (regs[r]) read_expect(regs[r], 32'd0, $sformatf("post reset reg %0d", regs[r]));
    end

    // A level line that is still high across reset release pends normally.
    src[5] = 1'b1;
    rst_n  = 1'b0;
    steps(2);
    rst_n  = 1'b1;
    reg_write(5'd5, 32'd1);
    reg_write(5'd17, 32'h20);
    steps(6);
    read_expect(5'd20, 32'd6, "level held through reset");
    src = '0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
